// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one 32-bit shift datapath (SLL / SRA) between two requesters,
// with a single registered response buffer routed back to the requester that owns it.
module shift_unit_arbiter #(
    parameter int unsigned PRIO_RESET = 0,
    parameter logic        OP_SLL     = 1'b0,
    parameter logic        OP_SRA     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic        req_op_0,
    input  logic [31:0] req_data_0,
    input  logic [4:0]  req_shamt_0,

    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic        req_op_1,
    input  logic [31:0] req_data_1,
    input  logic [4:0]  req_shamt_1,

    output logic        resp_valid_0,
    input  logic        resp_ready_0,
    output logic        resp_valid_1,
    input  logic        resp_ready_1,
    output logic [31:0] resp_data,
    output logic        busy
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        prio_q, prio_d;
    logic [31:0] data_q, data_d;

    logic        drain;
    logic        can_accept;
    logic        grant_valid;
    logic        grant_idx;
    logic        accept;
    logic [31:0] shift_result;

    function automatic logic [31:0] do_shift(input logic op, input logic [31:0] d,
                                             input logic [4:0] sh);
        logic [31:0] r;
        case (op)
            OP_SLL:  r = d << sh;
            OP_SRA:  r = $signed(d) >>> sh;
            default: r = d << sh;
        endcase
        return r;
    endfunction

    // Only the owner's resp_ready can free the buffer.
    assign drain      = (state_q == StFull) && (owner_q ? resp_ready_1 : resp_ready_0);
    assign can_accept = (state_q == StEmpty) || drain;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = prio_q;
        if (req_valid_0 && req_valid_1) begin
            grant_valid = 1'b1;
            grant_idx   = prio_q;
        end else if (req_valid_0) begin
            grant_valid = 1'b1;
            grant_idx   = 1'b0;
        end else if (req_valid_1) begin
            grant_valid = 1'b1;
            grant_idx   = 1'b1;
        end
    end

    assign req_ready_0 = can_accept && (grant_idx == 1'b0);
    assign req_ready_1 = can_accept && (grant_idx == 1'b1);
    assign accept      = can_accept && grant_valid;

    assign shift_result = grant_idx ? do_shift(req_op_1, req_data_1, req_shamt_1)
                                    : do_shift(req_op_0, req_data_0, req_shamt_0);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        data_d  = data_q;
        if (accept) begin
            state_d = StFull;
            owner_d = grant_idx;
            prio_d  = ~grant_idx;
            data_d  = shift_result;
        end else if (drain) begin
            // resp_data keeps its last value after draining.
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StEmpty;
            owner_q <= 1'b0;
            prio_q  <= (PRIO_RESET != 0);
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            data_q  <= data_d;
        end
    end

    assign resp_valid_0 = (state_q == StFull) && (owner_q == 1'b0);
    assign resp_valid_1 = (state_q == StFull) && (owner_q == 1'b1);
    assign resp_data    = data_q;
    assign busy         = (state_q == StFull);

endmodule

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
Shares one combinational 32-bit shift datapath (logical left shift plus arithmetic right shift) between two requesters: port 0 is the ALU pipeline and port 1 is the multdiv unit. The block arbitrates round-robin with a valid/ready handshake on each request port. It holds the result in a single registered response buffer and routes that result back to the requester that owns it. Result latency is one cycle, and back-to-back operations run at full throughput while responses drain.

Parameters:
PRIO_RESET, 0, requester that holds priority after reset (0 or 1)
OP_SLL, 1'b0, op encoding for a logical left shift
OP_SRA, 1'b1, op encoding for an arithmetic right shift

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid_0  input  1  requester 0 presents an operation
req_ready_0  output  1  requester 0 operation accepted this cycle when req_valid_0 & req_ready_0
req_op_0  input  1  requester 0 op (OP_SLL / OP_SRA)
req_data_0  input  32  requester 0 operand
req_shamt_0  input  5  requester 0 shift amount
req_valid_1, req_ready_1, req_op_1, req_data_1, req_shamt_1  same as port 0, for requester 1
resp_valid_0  output  1  result in buffer belongs to requester 0
resp_ready_0  input  1  requester 0 consumes result
resp_valid_1  output  1  result in buffer belongs to requester 1
resp_ready_1  input  1  requester 1 consumes result
resp_data  output  32  shared result bus, valid only when resp_valid_0 or resp_valid_1 is high
busy  output  1  response buffer occupied (EMPTY=0 / FULL=1)

Behaviour:
- Reset (synchronous, highest precedence):
  - buffer EMPTY; resp_valid_0 = resp_valid_1 = 0; resp_data = 0; busy = 0; priority pointer = PRIO_RESET.
  - A reset asserted mid-operation discards any buffered result; no response is delivered for it.
- States: EMPTY and FULL, tracked by a buffer-valid bit, with an owner register of 1 bit.
- drain = FULL & resp_ready_owner. resp_ready of the non-owner is ignored.
- can_accept = EMPTY | drain.
- Grant (combinational, evaluated each cycle):
  - Only one requester valid and can_accept -> grant it.
  - Both valid and can_accept -> grant the requester named by the priority pointer.
  - can_accept = 0 -> no grant.
  - req_ready_n = can_accept & (grant == n). req_ready must not depend on req_valid of its own port beyond the arbitration above, and no combinational path exists from resp_ready to req_ready other than through drain.
- On grant of requester n at edge k:
  - The buffer loads shift(req_op_n, req_data_n, req_shamt_n).
  - owner <= n; state FULL; resp_valid_n high from cycle k+1.
  - The priority pointer moves to the other requester (1-n) after every grant, whether contended or not.
- Drain with no grant -> EMPTY, resp_valid low next cycle, resp_data holds its last value.
- Drain and grant in the same cycle -> buffer reloads, stays FULL, owner updates; no bubble.
- FULL with no drain -> buffer, owner and resp_data are stable; both req_ready low.
- Arithmetic:
  - SLL fills with zeros.
  - SRA replicates bit 31.
  - shamt 0 passes the operand unchanged.
  - shamt is 0..31 with no wrap; the 5-bit field is used as-is.
- resp_valid_0 and resp_valid_1 are never high simultaneously.
- Each accepted request yields exactly one response, in acceptance order.

Test Plan:
- Reset, then requester 0 only: SRA 0x80000000 by 4 with resp_ready_0=1 -> req_ready_0=1 in the request cycle; next cycle resp_valid_0=1, resp_data=0xF8000000, busy=1.
- Requester 1 only: SLL 0x00000001 by 31 -> resp_valid_1=1, resp_data=0x80000000; SLL 0x12345678 by 0 -> 0x12345678.
- Both requesters valid continuously, both resp_ready=1, PRIO_RESET=0 -> grants alternate 0,1,0,1 on consecutive cycles with no idle cycle. Responses are owner-correct: 0: SRA 0x7FFFFFF0 by 4 -> 0x07FFFFFF; 1: SLL 0x0000000F by 8 -> 0x00000F00.
- Backpressure: owner 0 holds resp_ready_0=0 for 3 cycles while both request -> both req_ready=0, resp_data stable for 3 cycles, resp_ready_1=1 has no effect. On the release cycle requester 1 is granted in the same cycle (no bubble).
- Reset asserted while FULL with resp_ready low -> next cycle busy=0, both resp_valid=0, resp_data=0, and the priority pointer returns to PRIO_RESET.
- Randomized 1000-op bench versus a reference model -> every result matches, response order equals grant order, and no requester waits more than 2 grant opportunities under contention.
